// File: rtl/timer_compare_datapath.sv
// Datapath and status responder for the timer-compare controller: walks the calendar fields,
// runs the A/B ALU into R, reports c7/Az/Ts and times the alarm window.
module timer_compare_datapath #(
  parameter int unsigned W         = 6,
  parameter int unsigned NF        = 7,
  parameter int unsigned ALARM_CYC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NF*W-1:0] time_fields,
  input  logic [NF*W-1:0] timer_fields,
  input  logic            timer_arm,
  input  logic            timer_disarm,
  input  logic            alarm_clr,
  input  logic            Kc,
  input  logic            Cc,
  input  logic            La,
  input  logic            Lb,
  input  logic            Lr,
  input  logic [1:0]      s,
  input  logic            Ea,
  input  logic            Er,
  input  logic            M,
  output logic            c7,
  output logic            Az,
  output logic            Ts,
  output logic [2:0]      k_o,
  output logic [W-1:0]    bus_o,
  output logic            alarm_o
);

  localparam int unsigned CW = $clog2(ALARM_CYC + 1);

  logic [2:0]    k_q, k_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;
  logic          az_q, az_d;
  logic          ts_q, ts_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  time_fld, timer_fld, alu_res;

  // Field mux on the current (pre-update) index.
  always_comb begin
    time_fld  = '0;
    timer_fld = '0;
    for (int i = 0; i < int'(NF); i++) begin
      if (k_q == 3'(i)) begin
        time_fld  = time_fields[i*W +: W];
        timer_fld = timer_fields[i*W +: W];
      end
    end
  end

  always_comb begin
    alu_res = '0;
    unique case (s)
      2'b00: alu_res = a_q - b_q;
      2'b01: alu_res = a_q + b_q;
      2'b10: alu_res = a_q;
      2'b11: alu_res = b_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    k_d = k_q;
    if (Cc) begin
      k_d = '0;
    end else if (Kc) begin
      k_d = (k_q == 3'(NF - 1)) ? 3'd0 : k_q + 3'd1;
    end

    a_d  = La ? time_fld : a_q;
    b_d  = Lb ? timer_fld : b_q;
    r_d  = Lr ? alu_res : r_q;
    az_d = Lr ? (alu_res == '0) : az_q;

    ts_d = ts_q;
    if (timer_disarm) begin
      ts_d = 1'b0;
    end else if (timer_arm) begin
      ts_d = 1'b1;
    end else if (M && ts_q) begin
      ts_d = 1'b0;
    end

    // Alarm is high exactly while the counter is non-zero.
    cnt_d = cnt_q;
    if (alarm_clr) begin
      cnt_d = '0;
    end else if (M && ts_q) begin
      cnt_d = CW'(ALARM_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      az_q  <= 1'b1;
      ts_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      k_q   <= k_d;
      a_q   <= a_d;
      b_q   <= b_d;
      r_q   <= r_d;
      az_q  <= az_d;
      ts_q  <= ts_d;
      cnt_q <= cnt_d;
    end
  end

  assign c7      = (k_q == 3'(NF - 1));
  assign Az      = az_q;
  assign Ts      = ts_q;
  assign k_o     = k_q;
  assign alarm_o = (cnt_q != '0);
  assign bus_o   = Er ? r_q : (Ea ? a_q : '0);

endmodule
